// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: register-bank side bundle for counter_ctrl.
//   cfg_i    : REG_QUANTITY register words (0 CTRL, 1 LOAD, 2 LIMIT, 3 PRESCALE)
//   count_o  : current counter value
//   status_o : {ovf_sticky, done, running}
//   tick_o   : one-cycle pulse per prescaled count step
//   irq_o    : terminal interrupt pulse (present only with COUNTER_IRQ_EN)
// master = register bank / test driver, slave = counter_ctrl.
interface counter_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_QUANTITY = 6
);
    logic [DATA_WIDTH-1:0] cfg_i [REG_QUANTITY];
    logic [DATA_WIDTH-1:0] count_o;
    logic [2:0]            status_o;
    logic                  tick_o;
`ifdef COUNTER_IRQ_EN
    logic                  irq_o;

    modport master (output cfg_i, input count_o, input status_o, input tick_o, input irq_o);
    modport slave  (input cfg_i, output count_o, output status_o, output tick_o, output irq_o);
`else
    modport master (output cfg_i, input count_o, input status_o, input tick_o);
    modport slave  (input cfg_i, output count_o, output status_o, output tick_o);
`endif
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: prescaled up/down counter sequencer driven by register words.
// Ports:
//   clk    : system clock
//   areset : asynchronous active-low reset
//   bus    : counter_ctrl_if.slave (cfg_i in; count_o, status_o, tick_o, irq_o out)
// CTRL bits: [0] START, [1] STOP, [2] CLEAR, [3] DIR, [4] RELOAD, [5] IRQ_EN.
// Optional feature macro: COUNTER_IRQ_EN (adds irq_o, honours CTRL[5]).
module counter_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_QUANTITY = 6,
    parameter int PRESC_WIDTH  = 16
) (
    input  logic           clk,
    input  logic           areset,
    counter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             ctrl_q;
    logic [DATA_WIDTH-1:0]  count_q, count_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   pend_q, pend_d;   // reload owed on the next tick
    logic                   tick_q, tick_d;

    logic [DATA_WIDTH-1:0]  ctrl_w, load_w, limit_w, step_val;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   start_e, stop_e, clear_e, dir, reload;
    logic                   start_act, fresh_start, run_tick, terminal, wrap;
    logic                   unused_bits;

    assign ctrl_w   = bus.cfg_i[0];
    assign load_w   = bus.cfg_i[1];
    assign limit_w  = bus.cfg_i[2];
    assign prescale = bus.cfg_i[3][PRESC_WIDTH-1:0];
    assign dir      = ctrl_w[3];
    assign reload   = ctrl_w[4];

    assign start_e = ctrl_w[0] & ~ctrl_q[0];
    assign stop_e  = ctrl_w[1] & ~ctrl_q[1];
    assign clear_e = ctrl_w[2] & ~ctrl_q[2];

    // START only acts outside RUN and loses to CLEAR/STOP; in RUN it is
    // not an event and does not suppress the tick.
    assign start_act   = start_e & ~clear_e & ~stop_e & (state_q != RUN);
    assign fresh_start = start_act & (state_q != HOLD);
    assign run_tick    = (state_q == RUN) & ~clear_e & ~stop_e & (presc_q == prescale);
    assign step_val    = dir ? count_q - DATA_WIDTH'(1) : count_q + DATA_WIDTH'(1);
    // A reload tick loads LOAD and is never itself a terminal or a wrap.
    assign terminal    = run_tick & ~pend_q & (step_val == limit_w);
    assign wrap        = run_tick & ~pend_q & (dir ? (count_q == '0) : (count_q == '1));

    always_comb begin
        unused_bits = ^ctrl_w[DATA_WIDTH-1:6] ^ ^bus.cfg_i[3][DATA_WIDTH-1:PRESC_WIDTH];
        for (int unsigned i = 4; i < REG_QUANTITY; i++) begin
            unused_bits = unused_bits ^ ^bus.cfg_i[i];
        end
`ifndef COUNTER_IRQ_EN
        unused_bits = unused_bits ^ ctrl_w[5];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear_e) begin
            state_d = IDLE;
        end else if (stop_e) begin
            if (state_q == RUN) state_d = HOLD;
        end else if (start_act) begin
            state_d = RUN;
        end else if (terminal && !reload) begin
            state_d = DONE;
        end
    end

    // Datapath next values
    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        tick_d  = run_tick;
        if (clear_e) begin
            count_d = '0;
            presc_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            if (state_q != RUN || stop_e || run_tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_WIDTH'(1);
            end
            if (fresh_start) begin
                count_d = load_w;
                done_d  = 1'b0;
                pend_d  = 1'b0;
            end
            if (run_tick) begin
                if (pend_q) begin
                    count_d = load_w;
                    pend_d  = 1'b0;
                end else begin
                    count_d = step_val;
                    pend_d  = terminal & reload;
                    if (wrap)     ovf_d  = 1'b1;
                    if (terminal) done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_w[2:0];
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.count_o  = count_q;
    assign bus.status_o = {ovf_q, done_q, (state_q == RUN)};
    assign bus.tick_o   = tick_q;

`ifdef COUNTER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= terminal & ctrl_w[5];
        end
    end
    assign bus.irq_o = irq_q;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenarios plus randomized register traffic for
// counter_ctrl. Expected outputs come from a reference model of the
// counter rules and are queued; a monitor compares them against the DUT.
module tb_counter_ctrl;

    localparam logic [31:0] S = 32'd1, P = 32'd2, C = 32'd4, D = 32'd8, R = 32'd16, I = 32'd32;

    typedef struct {
        logic [31:0] count;
        logic [2:0]  status;
        logic        tick;
        logic        irq;
    } exp_t;

    logic clk = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    counter_ctrl_if #(.DATA_WIDTH(32), .REG_QUANTITY(6)) bus ();

    counter_ctrl #(.DATA_WIDTH(32), .REG_QUANTITY(6), .PRESC_WIDTH(16)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    logic [31:0] ctrl, load, limit, presc;
    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state (mode: 0 idle, 1 counting, 2 paused, 3 finished)
    int          m_mode;
    logic [31:0] m_count;
    int unsigned m_phase;
    bit          m_done, m_ovf, m_reload_owed;
    logic [2:0]  m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        bus.cfg_i[0] = ctrl;
        bus.cfg_i[1] = load;
        bus.cfg_i[2] = limit;
        bus.cfg_i[3] = presc;
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = '0; m_phase = 0;
        m_done = 0; m_ovf = 0; m_reload_owed = 0; m_prev = '0;
    endtask

    // Effect of the coming clock edge given the current register words.
    task automatic model_step();
        exp_t        e;
        logic [2:0]  rise;
        bit          tick, term;
        longint      nxt;
        rise   = ctrl[2:0] & ~m_prev;
        m_prev = ctrl[2:0];
        tick = 0; term = 0;
        if (rise[2]) begin
            m_mode = 0; m_count = '0; m_done = 0; m_ovf = 0; m_phase = 0; m_reload_owed = 0;
        end else if (rise[1]) begin
            if (m_mode == 1) begin m_mode = 2; m_phase = 0; end
        end else if (rise[0] && m_mode != 1) begin
            if (m_mode != 2) begin m_count = load; m_done = 0; m_reload_owed = 0; end
            m_mode = 1; m_phase = 0;
        end else if (m_mode == 1) begin
            if (m_phase == presc[15:0]) begin
                tick = 1; m_phase = 0;
                if (m_reload_owed) begin
                    m_count = load; m_reload_owed = 0;
                end else begin
                    nxt = longint'(m_count) + (ctrl[3] ? -64'sd1 : 64'sd1);
                    if (nxt < 0 || nxt > 64'sh0_FFFF_FFFF) m_ovf = 1;
                    m_count = nxt[31:0];
                    if (m_count == limit) begin
                        term = 1; m_done = 1;
                        if (ctrl[4]) m_reload_owed = 1; else m_mode = 3;
                    end
                end
            end else begin
                m_phase = (m_phase + 1) % 65536;
            end
        end
        e.count  = m_count;
        e.status = {m_ovf, m_done, m_mode == 1};
        e.tick   = tick;
        e.irq    = term && ctrl[5];
        exp_q.push_back(e);
    endtask

    // Called at negedge+1: queue the expectation, then advance one cycle.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            apply();
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        ctrl = 0; cyc();
        ctrl = C; cyc();
        ctrl = 0; cyc();
    endtask

    // Monitor: outputs are presented every cycle; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count_o", bus.count_o, e.count);
                chk("status_o", {29'd0, bus.status_o}, {29'd0, e.status});
                chk("tick_o", {31'd0, bus.tick_o}, {31'd0, e.tick});
`ifdef COUNTER_IRQ_EN
                chk("irq_o", {31'd0, bus.irq_o}, {31'd0, e.irq});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ctrl = 0; load = 0; limit = 0; presc = 0;
        apply();
        bus.cfg_i[4] = 32'hA5A5_0001;
        bus.cfg_i[5] = 32'h5A5A_0002;
        model_reset();
        #2;
        chk("reset count_o", bus.count_o, 32'd0);
        chk("reset status_o", {29'd0, bus.status_o}, 32'd0);
        chk("reset tick_o", {31'd0, bus.tick_o}, 32'd0);
        @(negedge clk); #1;
        areset = 1'b1;

        // 1: count 5..8 then DONE; held START does not restart
        load = 5; limit = 8; presc = 0;
        clear_all();
        ctrl = S; cyc(7);
        chk("t1 count", bus.count_o, 32'd8);
        chk("t1 status", {29'd0, bus.status_o}, 32'd2);

        // 2: prescale 2, steps at 3,6,9
        clear_all();
        load = 0; limit = 3; presc = 2;
        ctrl = S; cyc(10);
        chk("t2 count", bus.count_o, 32'd3);
        chk("t2 status", {29'd0, bus.status_o}, 32'd2);

        // 3: down count through zero
        clear_all();
        load = 1; limit = 32'hFFFF_FFFE; presc = 0;
        ctrl = D; cyc();
        ctrl = D | S; cyc(4);
        chk("t3 count", bus.count_o, 32'hFFFF_FFFE);
        chk("t3 status", {29'd0, bus.status_o}, 32'd6);

        // 4: reload loop 0,1,2,0,1,2,0
        clear_all();
        load = 0; limit = 2;
        ctrl = R | I; cyc();
        ctrl = R | I | S; cyc(7);
        chk("t4 count", bus.count_o, 32'd0);
        chk("t4 status", {29'd0, bus.status_o}, 32'd3);

        // 5: stop / resume / simultaneous edges / clear
        clear_all();
        load = 0; limit = 100;
        ctrl = S; cyc(5);
        ctrl = S | P; cyc();
        chk("t5 hold count", bus.count_o, 32'd4);
        chk("t5 hold status", {29'd0, bus.status_o}, 32'd0);
        ctrl = P; cyc();
        ctrl = P | S; cyc(2);
        chk("t5 resume count", bus.count_o, 32'd5);
        ctrl = 0; cyc();
        ctrl = S | P; cyc();
        chk("t5 both status", {29'd0, bus.status_o}, 32'd0);
        ctrl = C | S | P; cyc();
        chk("t5 clear count", bus.count_o, 32'd0);
        ctrl = 0; cyc();

        // 6: asynchronous reset mid-run
        load = 7;
        ctrl = S; cyc(2);
        areset = 1'b0;
        #1;
        chk("t6 async count", bus.count_o, 32'd0);
        chk("t6 async status", {29'd0, bus.status_o}, 32'd0);
        ctrl = 0; apply(); model_reset();
        @(negedge clk); #1;
        @(negedge clk); #1;
        areset = 1'b1;
        cyc(3);
        chk("t6 idle status", {29'd0, bus.status_o}, 32'd0);

        // Randomized register traffic
        limit = 6; load = 2; presc = 1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) ctrl[$urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) limit = $urandom_range(0, 12);
            if ($urandom_range(0, 15) == 0)
                load = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                   : 32'($urandom_range(0, 12));
            if (m_mode != 1 && $urandom_range(0, 7) == 0) presc = $urandom_range(0, 3);
            cyc();
        end

        @(negedge clk); #1;
        if (exp_q.size() != 0) chk("queue drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
